seg_pattern_decoder: RTL and testbench
======================================

# seg_pattern_decoder

Recovers a 0-9 digit from a 7-segment drive bus, the inverse of the per-digit segment driver, for loopback self-test and display readback in the clock. It samples the segment lines, rejects PWM dimming gaps and switching glitches by requiring a stable non-blank pattern, and decodes it to BCD. It also flags undecodable patterns and detects a display that has stayed dark.

## Interface
- STABLE_CYCLES, 4: consecutive identical non-blank samples required to commit a pattern (>=1)
- BLANK_TIMEOUT, 256: consecutive all-zero samples that declare the display blank (>=2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- seg_in  in  7  segment lines, bit0=a … bit6=g, 1 = segment lit
- digit_ff  out  4  decoded digit, 0-9
- valid_ff  out  1  digit_ff holds a committed, decodable digit
- error_ff  out  1  last committed pattern was not a legal digit
- blank_ff  out  1  display is dark (timeout reached)
- update_ff  out  1  one-cycle pulse whenever committed outputs change state

## Operation
- seg_in is registered once into seg_q. All logic below acts on seg_q.
- Legal patterns (hex, bit6..0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=67
  - Every other non-zero pattern is illegal.
- Registers:
  - cand: 7 bits
  - stab_cnt: width $clog2(STABLE_CYCLES+1)
  - zero_cnt: width $clog2(BLANK_TIMEOUT+1), saturating
- Any non-zero seg_q clears zero_cnt. A zero seg_q increments zero_cnt and leaves cand and stab_cnt untouched, so PWM off-time is ignored.
- States:
  - BLANK (reset state):
    - on a non-zero sample, cand<=seg_q, stab_cnt<=1, go to ACQUIRE.
  - ACQUIRE:
    - when seg_q==cand, stab_cnt increments.
    - when seg_q is non-zero and differs from cand, cand<=seg_q and stab_cnt<=1.
    - when stab_cnt reaches STABLE_CYCLES, commit and go to LOCKED.
  - LOCKED:
    - when seg_q==cand, no action.
    - when seg_q is non-zero and differs from cand, cand<=seg_q, stab_cnt<=1, go to ACQUIRE.
    - previous outputs are held until the next commit.
- Commit of a legal pattern: digit_ff<=code, valid_ff<=1, error_ff<=0, blank_ff<=0.
- Commit of an illegal pattern: digit_ff holds its value, valid_ff<=0, error_ff<=1, blank_ff<=0.
- Blank timeout: in ACQUIRE or LOCKED, when zero_cnt reaches BLANK_TIMEOUT, go to BLANK with digit_ff<=0, valid_ff<=0, error_ff<=0, blank_ff<=1.
- update_ff:
  - pulses for one cycle on every commit whose digit_ff, valid_ff, error_ff or blank_ff value differs from the current value.
  - pulses on BLANK entry when blank_ff was 0.
  - a re-commit of an identical pattern does not pulse.

## Timing
- Reset (asynchronous assert; release is synchronized externally): seg_q=0, cand=0, counters=0, state=BLANK, digit_ff=0, valid_ff=0, error_ff=0, blank_ff=1, update_ff=0.
- Reset asserted mid-operation returns immediately to these values. Resampling starts from BLANK.
- Define edge 0 as the edge that first loads a new stable pattern into seg_q. The commit happens on edge STABLE_CYCLES, and the outputs and update_ff are visible after that edge.
  - With STABLE_CYCLES=1, the commit happens on edge 1.
- Interleaved zero samples do not delay the commit in sample count; they only add wall-clock cycles.
- Blank: the last non-zero seg_q is followed by zeros from edge 1. The transition happens on edge BLANK_TIMEOUT, with blank_ff=1 and update_ff pulsing after that edge.
- Simultaneous events: a commit and a timeout cannot coincide, because a commit needs a non-zero sample and that sample clears zero_cnt.
- update_ff is high for exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- All outputs are registered; there is no combinational path from seg_in to any output.

## Test plan
- Reset, then hold seg_in=0x4F: after edge 4, digit_ff=3, valid_ff=1, blank_ff=0, and update_ff pulses once. Outputs hold steady afterwards.
- Drive 0x7D at 50% duty (alternating 0x7D/0x00), with STABLE_CYCLES=4: the commit happens after the 4th non-zero sample, giving digit_ff=6, with no blank and no pulses from the zero samples.
- Lock 5 (0x6D), then apply 0x7D for 2 samples and return to 0x6D: no output change and no update_ff.
- Lock 8, then apply 0x7F→0x49 held stable: after 4 samples, error_ff=1, valid_ff=0, digit_ff stays 8, and update_ff pulses.
- Lock 1, then drive seg_in=0 for 255 cycles: still locked. At cycle 256, blank_ff=1, digit_ff=0, valid_ff=0, and update_ff pulses once.
- Assert reset while in ACQUIRE on 0x07: all outputs take their reset values at once. After release, with 0x07 still driven, the commit happens 4 edges later and gives digit_ff=7.

Source files
------------

// File: rtl/seg_pattern_decoder_if.sv
// ============================================================================
// Module      : seg_pattern_decoder_if
// Description : Segment-bus and decoded-digit signal bundle for seg_pattern_decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface seg_pattern_decoder_if;
    logic [6:0] seg_in;
    logic [3:0] digit_ff;
    logic       valid_ff;
    logic       error_ff;
    logic       blank_ff;
    logic       update_ff;

    modport master (
        output seg_in,
        input  digit_ff,
        input  valid_ff,
        input  error_ff,
        input  blank_ff,
        input  update_ff
    );

    modport slave (
        input  seg_in,
        output digit_ff,
        output valid_ff,
        output error_ff,
        output blank_ff,
        output update_ff
    );
endinterface

`default_nettype wire

// File: rtl/seg_pattern_decoder.sv
// ============================================================================
// Module      : seg_pattern_decoder
// Description : Recovers a BCD digit from a 7-segment drive bus, filtering PWM
//               gaps and glitches, flagging illegal patterns and dark displays.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seg_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int BLANK_TIMEOUT = 256
) (
    input  wire logic           clk,
    input  wire logic           reset,
    seg_pattern_decoder_if.slave bus
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int ZW = $clog2(BLANK_TIMEOUT + 1);

    localparam logic [SW-1:0] c_STAB_ONE  = SW'(1);
    localparam logic [SW-1:0] c_STAB_TGT  = SW'(STABLE_CYCLES);
    localparam logic [ZW-1:0] c_ZERO_MAX  = ZW'(BLANK_TIMEOUT);
    // The zero already held in seg_q counts as the first dark sample, so the
    // timeout fires on the increment that brings the counter to BLANK_TIMEOUT-1.
    localparam logic [ZW-1:0] c_ZERO_TRIP = ZW'(BLANK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BLANK   = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t        r_state;
    logic [6:0]    r_seg_q;
    logic [6:0]    r_cand;
    logic [SW-1:0] r_stab_cnt;
    logic [ZW-1:0] r_zero_cnt;
    logic [3:0]    r_digit;
    logic          r_valid;
    logic          r_error;
    logic          r_blank;
    logic          r_update;

    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'h3F:   return {1'b1, 4'd0};
            7'h06:   return {1'b1, 4'd1};
            7'h5B:   return {1'b1, 4'd2};
            7'h4F:   return {1'b1, 4'd3};
            7'h66:   return {1'b1, 4'd4};
            7'h6D:   return {1'b1, 4'd5};
            7'h7D:   return {1'b1, 4'd6};
            7'h07:   return {1'b1, 4'd7};
            7'h7F:   return {1'b1, 4'd8};
            7'h67:   return {1'b1, 4'd9};
            default: return 5'b0_0000;
        endcase
    endfunction

    logic          w_nonzero;
    logic          w_match;
    logic          w_load;
    logic          w_commit;
    logic          w_timeout;
    logic [4:0]    w_dec;
    logic          w_legal;
    logic [3:0]    w_next_digit;
    logic          w_commit_chg;
    logic [SW-1:0] w_stab_inc;
    logic [ZW-1:0] w_zero_inc;

    always_comb begin
        w_nonzero    = (r_seg_q != 7'd0);
        w_match      = (r_seg_q == r_cand);
        w_stab_inc   = r_stab_cnt + 1'b1;
        w_zero_inc   = (r_zero_cnt == c_ZERO_MAX) ? r_zero_cnt : r_zero_cnt + 1'b1;
        w_dec        = f_decode(r_seg_q);
        w_legal      = w_dec[4];
        w_next_digit = w_legal ? w_dec[3:0] : r_digit;

        // Any non-zero sample outside a matching ACQUIRE/LOCKED becomes the new candidate.
        w_load       = w_nonzero && !((r_state != S_BLANK) && w_match);

        w_commit     = 1'b0;
        if (w_nonzero) begin
            if ((r_state == S_ACQUIRE) && w_match) begin
                w_commit = (w_stab_inc == c_STAB_TGT);
            end else if (w_load) begin
                w_commit = (STABLE_CYCLES == 1);
            end
        end

        w_timeout    = !w_nonzero && (r_state != S_BLANK) && (w_zero_inc == c_ZERO_TRIP);

        w_commit_chg = (w_next_digit != r_digit) || (w_legal != r_valid) ||
                       (w_legal == r_error) || r_blank;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BLANK;
            r_seg_q    <= 7'd0;
            r_cand     <= 7'd0;
            r_stab_cnt <= '0;
            r_zero_cnt <= '0;
            r_digit    <= 4'd0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_blank    <= 1'b1;
            r_update   <= 1'b0;
        end else begin
            r_seg_q    <= bus.seg_in;
            r_zero_cnt <= w_nonzero ? '0 : w_zero_inc;
            r_update   <= 1'b0;

            if (w_load) begin
                r_cand     <= r_seg_q;
                r_stab_cnt <= c_STAB_ONE;
            end else if (w_nonzero && (r_state == S_ACQUIRE)) begin
                r_stab_cnt <= w_stab_inc;
            end

            if (w_commit) begin
                r_state  <= S_LOCKED;
                r_digit  <= w_next_digit;
                r_valid  <= w_legal;
                r_error  <= !w_legal;
                r_blank  <= 1'b0;
                r_update <= w_commit_chg;
            end else if (w_timeout) begin
                r_state  <= S_BLANK;
                r_digit  <= 4'd0;
                r_valid  <= 1'b0;
                r_error  <= 1'b0;
                r_blank  <= 1'b1;
                r_update <= !r_blank;
            end else if (w_load) begin
                r_state  <= S_ACQUIRE;
            end
        end
    end

    assign bus.digit_ff  = r_digit;
    assign bus.valid_ff  = r_valid;
    assign bus.error_ff  = r_error;
    assign bus.blank_ff  = r_blank;
    assign bus.update_ff = r_update;

endmodule

`default_nettype wire

// File: tb/tb_seg_pattern_decoder.sv
// ============================================================================
// Module      : tb_seg_pattern_decoder
// Description : Scoreboard bench for seg_pattern_decoder with directed vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_seg_pattern_decoder;

    typedef struct {
        int         cyc;
        logic [3:0] digit;
        logic       valid;
        logic       error;
        logic       blank;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_n   = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    exp_t exp_q[$];

    seg_pattern_decoder_if u_if ();

    seg_pattern_decoder #(
        .STABLE_CYCLES (4),
        .BLANK_TIMEOUT (256)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input int cyc, input logic [3:0] d, input logic v,
                        input logic e, input logic b);
        exp_t x;
        x.cyc = cyc; x.digit = d; x.valid = v; x.error = e; x.blank = b;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            u_if.seg_in = v;
            @(negedge clk);
        end
    endtask

    // Monitor: every update pulse must match the next expected event.
    always @(negedge clk) begin
        if (reset && u_if.update_ff) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_update: edge %0d digit %0d valid %0d error %0d blank %0d, required no pulse",
                         edge_n, u_if.digit_ff, u_if.valid_ff, u_if.error_ff, u_if.blank_ff);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (x.cyc != edge_n || x.digit != u_if.digit_ff || x.valid != u_if.valid_ff ||
                    x.error != u_if.error_ff || x.blank != u_if.blank_ff) begin
                    n_bad++;
                    $display("FAIL update_event: got edge %0d d%0d v%0d e%0d b%0d, required edge %0d d%0d v%0d e%0d b%0d",
                             edge_n, u_if.digit_ff, u_if.valid_ff, u_if.error_ff, u_if.blank_ff,
                             x.cyc, x.digit, x.valid, x.error, x.blank);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset       = 1'b0;
        u_if.seg_in = 7'h00;
        repeat (3) @(negedge clk);
        chk("reset_digit",  u_if.digit_ff,  0);
        chk("reset_valid",  u_if.valid_ff,  0);
        chk("reset_error",  u_if.error_ff,  0);
        chk("reset_blank",  u_if.blank_ff,  1);
        chk("reset_update", u_if.update_ff, 0);
        reset = 1'b1;

        // Steady 3
        e = edge_n;
        push(e + 5, 4'd3, 1'b1, 1'b0, 1'b0);
        step(7'h4F, 10);
        chk("t1_digit", u_if.digit_ff, 3);
        chk("t1_valid", u_if.valid_ff, 1);
        chk("t1_blank", u_if.blank_ff, 0);

        // 6 at 50% duty: four non-zero samples needed
        e = edge_n;
        push(e + 8, 4'd6, 1'b1, 1'b0, 1'b0);
        repeat (4) begin
            step(7'h7D, 1);
            step(7'h00, 1);
        end
        step(7'h7D, 4);
        chk("t2_digit", u_if.digit_ff, 6);
        chk("t2_blank", u_if.blank_ff, 0);

        // Lock 5, short glitch to 7D, back to 5: no change
        e = edge_n;
        push(e + 5, 4'd5, 1'b1, 1'b0, 1'b0);
        step(7'h6D, 6);
        step(7'h7D, 2);
        step(7'h6D, 8);
        chk("t3_digit", u_if.digit_ff, 5);
        chk("t3_valid", u_if.valid_ff, 1);

        // Lock 8, then illegal 49
        e = edge_n;
        push(e + 5, 4'd8, 1'b1, 1'b0, 1'b0);
        step(7'h7F, 6);
        e = edge_n;
        push(e + 5, 4'd8, 1'b0, 1'b1, 1'b0);
        step(7'h49, 6);
        chk("t4_error", u_if.error_ff, 1);
        chk("t4_valid", u_if.valid_ff, 0);
        chk("t4_digit", u_if.digit_ff, 8);

        // Lock 1, then dark for the timeout
        e = edge_n;
        push(e + 5, 4'd1, 1'b1, 1'b0, 1'b0);
        step(7'h06, 6);
        e = edge_n;
        step(7'h00, 255);
        chk("t5_pre_blank", u_if.blank_ff, 0);
        chk("t5_pre_valid", u_if.valid_ff, 1);
        chk("t5_pre_digit", u_if.digit_ff, 1);
        push(e + 256, 4'd0, 1'b0, 1'b0, 1'b1);
        step(7'h00, 3);
        chk("t5_blank", u_if.blank_ff, 1);
        chk("t5_digit", u_if.digit_ff, 0);
        chk("t5_valid", u_if.valid_ff, 0);

        // Lock 9, enter ACQUIRE on 07, reset mid-acquire
        e = edge_n;
        push(e + 5, 4'd9, 1'b1, 1'b0, 1'b0);
        step(7'h67, 6);
        step(7'h07, 2);
        chk("t6_pre_digit", u_if.digit_ff, 9);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_digit",  u_if.digit_ff,  0);
        chk("t6_rst_valid",  u_if.valid_ff,  0);
        chk("t6_rst_error",  u_if.error_ff,  0);
        chk("t6_rst_blank",  u_if.blank_ff,  1);
        chk("t6_rst_update", u_if.update_ff, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        e = edge_n;
        push(e + 5, 4'd7, 1'b1, 1'b0, 1'b0);
        step(7'h07, 8);
        chk("t6_digit", u_if.digit_ff, 7);
        chk("t6_valid", u_if.valid_ff, 1);

        step(7'h07, 2);
        chk("pending_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
